spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
Parametrised successor to the team's 10-bit SPI slave. It samples MOSI once per system clock while SS_n is low and deserialises a control bit plus an RX_W-bit word into rx_data. For read-data frames it serialises a DATA_W-bit response on MISO through a valid/ready handshake with the memory side. It adds mid-frame abort detection, a tracked read-address/read-data sequence, and a registered busy indication.

Parameters:
DATA_W, 8, payload width; RX_W = DATA_W+2 (localparam, command[1:0] + payload)
MISO_IDLE, 1'b0, MISO level when not shifting
CNT_W, $clog2(DATA_W+3), bit counter width (localparam)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
SS_n  in  1  slave select, active low, synchronous to clk
MOSI  in  1  serial in, sampled on posedge clk
MISO  out  1  serial out, registered
rx_data  out  RX_W  last complete received word, MSB = first received payload bit
rx_valid  out  1  one-cycle pulse when rx_data updates
tx_data  in  DATA_W  read response
tx_valid  in  1  tx_data valid
tx_ready  out  1  high in TX_WAIT; transfer on tx_valid & tx_ready
frame_err  out  1  one-cycle pulse on aborted or illegal frame
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1, async): state IDLE, rx_data=0, rx_valid=0, MISO=MISO_IDLE, tx_ready=0, frame_err=0, busy=0, rd_addr_seen=0, counters and shift registers cleared.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
- IDLE: SS_n=0 -> CHK_CMD. The MOSI value in this cycle is ignored.
- CHK_CMD: MOSI is the control bit. 0 -> WRITE; 1 with rd_addr_seen=0 -> READ_ADD; 1 with rd_addr_seen=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift one MOSI bit per clk, MSB-first (shift left, new bit at LSB), for RX_W cycles.
  - On the RX_W-th bit, the rx_data/rx_valid registers load the full word (current bit included) and rx_valid pulses in the following cycle.
  - WRITE -> DONE.
  - READ_ADD -> DONE and sets rd_addr_seen.
  - READ_DATA -> TX_WAIT.
- Command check: a READ_ADD word whose rx_data[RX_W-1:RX_W-2] != 2'b10, or a READ_DATA word != 2'b11, still delivers rx_valid, also pulses frame_err, and goes to DONE. No TX occurs and rd_addr_seen is unchanged.
- TX_WAIT: tx_ready=1 (registered, asserted on entry). On tx_valid, capture tx_data, clear tx_ready, go TX_SHIFT.
- TX_SHIFT: MISO takes tx_shift[DATA_W-1] each clk, MSB-first, for exactly DATA_W cycles. Then MISO=MISO_IDLE, rd_addr_seen clears, go DONE.
- DONE: ignore MOSI; hold until SS_n=1 -> IDLE.
- Abort rule (all states except IDLE/DONE): SS_n=1 -> IDLE next cycle, frame_err pulses, no rx_valid, rd_addr_seen unchanged, MISO=MISO_IDLE, tx_ready=0.
  - SS_n rising in the same cycle as the last RX bit counts as an abort.
  - A tx_valid coinciding with SS_n=1 in TX_WAIT is not accepted.
- Back-to-back frames: SS_n high for one clk (DONE -> IDLE) then low again is legal. Minimum gap is 1 cycle.
- tx_valid is ignored outside TX_WAIT. tx_data is only sampled at the handshake.
- Counter: CNT_W bits, cleared on every state entry, never wraps within a frame.

Decomposition:
- Package spi_slave_pkg: state enum (3-bit encoding as listed) and command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- One sub-module: spi_tx_shifter (DATA_W; load, shift_en, MISO out, done pulse). FSM, RX shift, and flags stay in the top.

Test Plan:
- Write, DATA_W=8: SS_n low, ctrl 0, bits 10'b00_1010_0101 -> rx_data=10'h0A5 one cycle after 10th bit, rx_valid high exactly 1 cycle, frame_err=0, MISO=0.
- Read address then read data: frame 1 ctrl 1 + 10'b10_0000_0011 -> rx_data=10'h203, rd_addr_seen=1. Frame 2 ctrl 1 + 10'b11_0000_0000 -> rx_valid, tx_ready=1; tx_valid with tx_data=8'hC3 after 3 idle cycles -> MISO=1,1,0,0,0,0,1,1 on 8 consecutive clks, then rd_addr_seen=0.
- Abort: SS_n high after 5 payload bits of a write -> frame_err 1-cycle pulse, no rx_valid, rx_data holds prior 10'h0A5, busy=0 next cycle.
- Illegal command: read-address frame carrying 10'b01_1111_0000 -> rx_valid and frame_err in same cycle, no tx_ready, next ctrl-1 frame enters READ_ADD again.
- Reset mid-TX: assert rst during 4th MISO bit -> all outputs at reset values immediately (async), next frame behaves as first-ever frame.
- Abort in TX_WAIT with tx_valid=1 in same cycle as SS_n rise -> no capture, frame_err pulse, MISO stays 0.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the parametrised SPI slave: FSM state codes and
// the two-bit command field carried at the top of every received word.
package spi_slave_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_CHK_CMD   = 3'd1;
   localparam state_t ST_WRITE     = 3'd2;
   localparam state_t ST_READ_ADD  = 3'd3;
   localparam state_t ST_READ_DATA = 3'd4;
   localparam state_t ST_TX_WAIT   = 3'd5;
   localparam state_t ST_TX_SHIFT  = 3'd6;
   localparam state_t ST_DONE      = 3'd7;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// MSB-first serialiser for the read response. MISO is registered and falls
// back to the idle level on any cycle the shifter is not enabled.
module spi_tx_shifter #(
   parameter int   DATA_W    = 8,
   parameter logic MISO_IDLE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   input  logic              shift_en,
   output logic              miso,
   output logic              done
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift <= '0;
         cnt   <= '0;
         miso  <= MISO_IDLE;
      end else if (load) begin
         shift <= data;
         cnt   <= '0;
         miso  <= MISO_IDLE;
      end else if (shift_en) begin
         miso  <= shift[DATA_W-1];
         shift <= shift << 1;
         cnt   <= cnt + 1'b1;
      end else begin
         miso  <= MISO_IDLE;
      end
   end

   // Asserted alongside the edge that launches the final bit.
   assign done = shift_en && (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises control bit + command/payload word,
// answers read-data frames through a valid/ready handshake, flags aborts.
module spi_slave_param
   import spi_slave_pkg::*;
#(
   parameter  int   DATA_W    = 8,
   parameter  logic MISO_IDLE = 1'b0,
   localparam int   RX_W      = DATA_W + 2,
   localparam int   CNT_W     = $clog2(DATA_W + 3)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [RX_W-1:0]   rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              frame_err,
   output logic              busy
);

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  cnt;
   logic [RX_W-2:0]   rx_shift;
   logic [RX_W-1:0]   rx_word;
   logic              rd_addr_seen;
   logic              rx_state;
   logic              last_bit;
   logic              cmd_ok;
   logic              abort;
   logic              tx_load;
   logic              shift_en;
   logic              tx_done;

   assign rx_word  = {rx_shift, MOSI};
   assign rx_state = (state == ST_WRITE) || (state == ST_READ_ADD) || (state == ST_READ_DATA);
   assign last_bit = (cnt == CNT_W'(RX_W - 1));
   assign tx_load  = (state == ST_TX_WAIT) && !SS_n && tx_valid;
   assign shift_en = (state == ST_TX_SHIFT) && !SS_n;

   always_comb begin
      next_state = state;
      abort      = 1'b0;
      cmd_ok     = 1'b1;
      if (state == ST_READ_ADD)
         cmd_ok = (rx_word[RX_W-1 -: 2] == CMD_RD_ADDR);
      else if (state == ST_READ_DATA)
         cmd_ok = (rx_word[RX_W-1 -: 2] == CMD_RD_DATA);

      case (state)
         ST_IDLE:      if (!SS_n) next_state = ST_CHK_CMD;
         ST_CHK_CMD: begin
            if (SS_n)          abort      = 1'b1;
            else if (!MOSI)    next_state = ST_WRITE;
            else               next_state = rd_addr_seen ? ST_READ_DATA : ST_READ_ADD;
         end
         ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            if (SS_n)
               abort = 1'b1;
            else if (last_bit)
               next_state = (cmd_ok && state == ST_READ_DATA) ? ST_TX_WAIT : ST_DONE;
         end
         ST_TX_WAIT: begin
            if (SS_n)          abort      = 1'b1;
            else if (tx_valid) next_state = ST_TX_SHIFT;
         end
         ST_TX_SHIFT: begin
            if (SS_n)          abort      = 1'b1;
            else if (tx_done)  next_state = ST_DONE;
         end
         ST_DONE:      if (SS_n) next_state = ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase

      if (abort)
         next_state = ST_IDLE;
   end

   // The bit counter restarts on every state change so each phase counts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         cnt          <= '0;
         rx_shift     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         tx_ready     <= 1'b0;
         frame_err    <= 1'b0;
         rd_addr_seen <= 1'b0;
      end else begin
         state     <= next_state;
         busy      <= (next_state != ST_IDLE);
         tx_ready  <= (next_state == ST_TX_WAIT);
         rx_valid  <= 1'b0;
         frame_err <= abort || (rx_state && !SS_n && last_bit && !cmd_ok);

         if (next_state != state)
            cnt <= '0;
         else if (rx_state)
            cnt <= cnt + 1'b1;

         if (rx_state && !SS_n)
            rx_shift <= rx_word[RX_W-2:0];

         if (rx_state && !SS_n && last_bit) begin
            rx_data  <= rx_word;
            rx_valid <= 1'b1;
            if (cmd_ok && state == ST_READ_ADD)
               rd_addr_seen <= 1'b1;
         end

         if (tx_done)
            rd_addr_seen <= 1'b0;
      end
   end

   spi_tx_shifter #(
      .DATA_W    (DATA_W),
      .MISO_IDLE (MISO_IDLE)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .load     (tx_load),
      .data     (tx_data),
      .shift_en (shift_en),
      .miso     (MISO),
      .done     (tx_done)
   );

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param: directed vector table, hand-written
// corner sequences, then random frames against a frame-level reference model.
module tb_spi_slave_param;

   localparam int   DATA_W = 8;
   localparam int   RX_W   = DATA_W + 2;
   localparam logic IDLE_LVL = 1'b0;

   logic              clk = 1'b0;
   logic              rst;
   logic              SS_n;
   logic              MOSI;
   logic              MISO;
   logic [RX_W-1:0]   rx_data;
   logic              rx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              frame_err;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // Frame-level reference state: read-address seen flag and last delivered word.
   logic            model_seen = 1'b0;
   logic [RX_W-1:0] model_last = '0;

   typedef struct {
      int              kind;
      logic            ctrl;
      logic [RX_W-1:0] word;
      int              nbits;
      int              wait_cyc;
      logic [7:0]      txd;
      logic            exp_err;
      logic            exp_tx;
   } vec_t;

   vec_t vecs[12];

   spi_slave_param #(.DATA_W(DATA_W), .MISO_IDLE(IDLE_LVL)) dut (
      .clk       (clk),
      .rst       (rst),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Frame outcome from the command rules alone.
   task automatic predict(input logic ctrl, input logic [RX_W-1:0] word,
                          output logic err, output logic tx);
      err = 1'b0;
      tx  = 1'b0;
      if (ctrl) begin
         if (!model_seen) err = (word[RX_W-1:RX_W-2] != 2'b10);
         else begin
            err = (word[RX_W-1:RX_W-2] != 2'b11);
            tx  = !err;
         end
      end
   endtask

   task automatic shift_in(input logic ctrl, input logic [RX_W-1:0] word);
      SS_n = 1'b0;
      MOSI = 1'($urandom);
      tick();
      check_output("busy_start", busy, 1);
      MOSI = ctrl;
      tick();
      for (int i = RX_W - 1; i >= 0; i--) begin
         MOSI = word[i];
         tick();
         if (i != 0) check_output("rx_valid_early", rx_valid, 0);
      end
   endtask

   task automatic run_frame(input logic ctrl, input logic [RX_W-1:0] word, input logic exp_err,
                            input logic exp_tx, input int wait_cyc, input logic [7:0] txd);
      shift_in(ctrl, word);
      check_output("rx_valid", rx_valid, 1);
      check_output("rx_data", rx_data, word);
      check_output("frame_err_end", frame_err, exp_err);
      check_output("tx_ready_end", tx_ready, exp_tx);
      check_output("miso_rx", MISO, IDLE_LVL);
      model_last = word;
      if (exp_tx) begin
         for (int w = 0; w < wait_cyc; w++) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            tick();
            check_output("tx_ready_wait", tx_ready, 1);
            check_output("rx_valid_pulse", rx_valid, 0);
            check_output("miso_wait", MISO, IDLE_LVL);
         end
         tx_valid = 1'b1;
         tx_data  = txd;
         tick();
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
         check_output("tx_ready_hs", tx_ready, 0);
         check_output("rx_valid_pulse", rx_valid, 0);
         for (int i = 7; i >= 0; i--) begin
            tick();
            check_output("miso_bit", MISO, txd[i]);
         end
         tick();
         check_output("miso_after", MISO, IDLE_LVL);
         check_output("busy_done", busy, 1);
         model_seen = 1'b0;
      end else begin
         tick();
         check_output("rx_valid_pulse", rx_valid, 0);
         check_output("frame_err_pulse", frame_err, 0);
         check_output("busy_done", busy, 1);
         if (ctrl && !exp_err) model_seen = 1'b1;
      end
      SS_n = 1'b1;
      tick();
      check_output("busy_idle", busy, 0);
      check_output("frame_err_idle", frame_err, 0);
   endtask

   // nbits < 0 raises SS_n in the control-bit cycle.
   task automatic abort_frame(input logic ctrl, input int nbits);
      SS_n = 1'b0;
      MOSI = 1'($urandom);
      tick();
      if (nbits >= 0) begin
         MOSI = ctrl;
         tick();
         for (int i = 0; i < nbits; i++) begin
            MOSI = 1'($urandom);
            tick();
            check_output("rx_valid_abort_early", rx_valid, 0);
         end
      end
      SS_n = 1'b1;
      tick();
      check_output("abort_err", frame_err, 1);
      check_output("abort_rx_valid", rx_valid, 0);
      check_output("abort_busy", busy, 0);
      check_output("abort_rx_data", rx_data, model_last);
      check_output("abort_tx_ready", tx_ready, 0);
      check_output("abort_miso", MISO, IDLE_LVL);
      tick();
      check_output("abort_err_pulse", frame_err, 0);
   endtask

   task automatic apply_stimulus(input vec_t v);
      if (v.kind == 0) run_frame(v.ctrl, v.word, v.exp_err, v.exp_tx, v.wait_cyc, v.txd);
      else             abort_frame(v.ctrl, v.nbits);
   endtask

   initial begin
      logic ctrl, err, tx;
      logic [RX_W-1:0] word;

      vecs[0]  = '{0, 1'b0, 10'h0A5, 0, 0, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{1, 1'b0, 10'h000, 5, 0, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{0, 1'b1, 10'h203, 0, 0, 8'h00, 1'b0, 1'b0};
      vecs[3]  = '{0, 1'b1, 10'h300, 0, 3, 8'hC3, 1'b0, 1'b1};
      vecs[4]  = '{0, 1'b1, 10'h1F0, 0, 0, 8'h00, 1'b1, 1'b0};
      vecs[5]  = '{0, 1'b1, 10'h3FF, 0, 0, 8'h00, 1'b1, 1'b0};
      vecs[6]  = '{0, 1'b1, 10'h2AA, 0, 0, 8'h00, 1'b0, 1'b0};
      vecs[7]  = '{1, 1'b1, 10'h000, 9, 0, 8'h00, 1'b0, 1'b0};
      vecs[8]  = '{0, 1'b1, 10'h2AA, 0, 0, 8'h00, 1'b1, 1'b0};
      vecs[9]  = '{0, 1'b1, 10'h3C5, 0, 0, 8'h5A, 1'b0, 1'b1};
      vecs[10] = '{0, 1'b0, 10'h3FF, 0, 0, 8'h00, 1'b0, 1'b0};
      vecs[11] = '{1, 1'b1, 10'h000, -1, 0, 8'h00, 1'b0, 1'b0};

      rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
      tick();
      tick();
      check_output("reset_rx_data", rx_data, 0);
      check_output("reset_rx_valid", rx_valid, 0);
      check_output("reset_miso", MISO, IDLE_LVL);
      check_output("reset_tx_ready", tx_ready, 0);
      check_output("reset_frame_err", frame_err, 0);
      check_output("reset_busy", busy, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) apply_stimulus(vecs[i]);

      // Abort in TX_WAIT while tx_valid is high: must not be captured.
      run_frame(1'b1, 10'h281, 1'b0, 1'b0, 0, 8'h00);
      shift_in(1'b1, 10'h3A5);
      check_output("txw_tx_ready", tx_ready, 1);
      model_last = 10'h3A5;
      SS_n = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
      tick();
      tx_valid = 1'b0;
      check_output("txw_abort_err", frame_err, 1);
      check_output("txw_tx_ready", tx_ready, 0);
      check_output("txw_busy", busy, 0);
      check_output("txw_miso", MISO, IDLE_LVL);
      tick();
      check_output("txw_miso_hold", MISO, IDLE_LVL);
      check_output("txw_err_pulse", frame_err, 0);
      run_frame(1'b1, 10'h30F, 1'b0, 1'b1, 1, 8'h81);

      // Asynchronous reset during the fourth MISO bit.
      run_frame(1'b1, 10'h2F0, 1'b0, 1'b0, 0, 8'h00);
      shift_in(1'b1, 10'h3E1);
      check_output("rst_tx_ready", tx_ready, 1);
      tx_valid = 1'b1; tx_data = 8'hB4;
      tick();
      tx_valid = 1'b0;
      for (int i = 7; i >= 4; i--) begin
         tick();
         check_output("rst_miso_bit", MISO, tx_data[i]);
      end
      rst = 1'b1;
      #1;
      check_output("async_rx_data", rx_data, 0);
      check_output("async_rx_valid", rx_valid, 0);
      check_output("async_miso", MISO, IDLE_LVL);
      check_output("async_tx_ready", tx_ready, 0);
      check_output("async_busy", busy, 0);
      check_output("async_frame_err", frame_err, 0);
      SS_n = 1'b1;
      tick();
      rst = 1'b0;
      model_seen = 1'b0;
      model_last = '0;
      tick();
      run_frame(1'b1, 10'h3FF, 1'b1, 1'b0, 0, 8'h00);
      run_frame(1'b1, 10'h2C3, 1'b0, 1'b0, 0, 8'h00);

      // Random frames judged by the reference model.
      for (int n = 0; n < 60; n++) begin
         ctrl = 1'($urandom);
         word = 10'($urandom);
         case ($urandom_range(0, 2))
            0: word[RX_W-1:RX_W-2] = 2'b10;
            1: word[RX_W-1:RX_W-2] = 2'b11;
            default: ;
         endcase
         if ($urandom_range(0, 4) == 0) begin
            abort_frame(ctrl, int'($urandom_range(0, 10)) - 1);
         end else begin
            predict(ctrl, word, err, tx);
            run_frame(ctrl, word, err, tx, int'($urandom_range(0, 4)), 8'($urandom));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
